// File: rtl/spike_fanout_dispatcher_if.sv
// Bundle of spike input, weight-matrix read port and synaptic event output.
// Latency: none (wires only).
// Backpressure: spike_valid/spike_ready and syn_valid/syn_ready handshakes.
interface spike_fanout_dispatcher_if #(
  parameter int numwidth = 16,
  parameter int tagbits  = 1
);
  logic                spike_valid;
  logic [tagbits-1:0]  spike_tag;
  logic                spike_ready;

  logic [tagbits-1:0]  wm_src_tag;
  logic [tagbits-1:0]  wm_dst_tag;
  logic [numwidth:0]   wm_weight;

  logic                syn_valid;
  logic                syn_ready;
  logic [tagbits-1:0]  syn_src;
  logic [tagbits-1:0]  syn_dst;
  logic [numwidth:0]   syn_weight;

  // Dispatcher side.
  modport master (
    input  spike_valid, spike_tag, wm_weight, syn_ready,
    output spike_ready, wm_src_tag, wm_dst_tag,
           syn_valid, syn_src, syn_dst, syn_weight
  );

  // Environment side: spike source, weight matrix and accumulator.
  modport slave (
    output spike_valid, spike_tag, wm_weight, syn_ready,
    input  spike_ready, wm_src_tag, wm_dst_tag,
           syn_valid, syn_src, syn_dst, syn_weight
  );
endinterface

// File: rtl/spike_fanout_dispatcher.sv
// Buffers spike tags and sweeps one weight-matrix row per spike, emitting weighted events.
// Latency: first event valid 2 edges after a push into an empty idle block; 2 cycles/event, 1 per skipped weight.
// Backpressure: syn_ready low holds the event; spike_ready = !fifo_full. Option macro DISPATCH_SKIP_ZERO_EN skips zero weights.
module spike_fanout_dispatcher #(
  parameter int numwidth   = 16,
  parameter int tagbits    = 1,
  parameter int numneurons = 2,
  parameter int fifodepth  = 4,
  parameter int fifobits   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spike_fanout_dispatcher_if.master  bus,
  output logic                       busy,
  output logic                       sweep_done
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  localparam logic [tagbits-1:0] last_dst = tagbits'(numneurons - 1);
  localparam logic [fifobits:0]  full_cnt = (fifobits + 1)'(fifodepth);

  // Spike tag FIFO
  logic [tagbits-1:0]  fifo_mem [fifodepth];
  logic [fifobits-1:0] wr_ptr;
  logic [fifobits-1:0] rd_ptr;
  logic [fifobits:0]   count;
  logic                push;
  logic                pop;

  // Sweep state
  state_t              state, state_n;
  logic [tagbits-1:0]  cur_src, cur_src_n;
  logic [tagbits-1:0]  dst_cnt, dst_n;
  logic [tagbits-1:0]  wm_src_q, wm_dst_q;

  // Registered event outputs
  logic                syn_valid_q, syn_valid_n;
  logic [tagbits-1:0]  syn_src_q, syn_src_n;
  logic [tagbits-1:0]  syn_dst_q, syn_dst_n;
  logic [numwidth:0]   syn_weight_q, syn_weight_n;
  logic                done_q, done_n;
  logic                emittable;

  // A full FIFO refuses spikes even if a pop happens this cycle: no pass-through.
  assign bus.spike_ready = (count != full_cnt);
  assign push            = bus.spike_valid && bus.spike_ready;
  assign pop             = (state == IDLE) && (count != '0);

`ifdef DISPATCH_SKIP_ZERO_EN
  // Zero magnitude means no connection, whatever the sign bit says.
  assign emittable = (bus.wm_weight[numwidth-1:0] != '0);
`else
  assign emittable = 1'b1;
`endif

  // Matrix address is live during SCAN and holds its last value otherwise.
  assign bus.wm_src_tag = (state == SCAN) ? cur_src : wm_src_q;
  assign bus.wm_dst_tag = (state == SCAN) ? dst_cnt : wm_dst_q;

  assign bus.syn_valid  = syn_valid_q;
  assign bus.syn_src    = syn_src_q;
  assign bus.syn_dst    = syn_dst_q;
  assign bus.syn_weight = syn_weight_q;
  assign sweep_done     = done_q;
  assign busy           = (state != IDLE) || (count != '0);

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.spike_tag;
    end
  end

  // FIFO pointers and occupancy; wrap is natural modulo the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sweep state and event registers; reset drops syn_valid asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_src      <= '0;
      dst_cnt      <= '0;
      wm_src_q     <= '0;
      wm_dst_q     <= '0;
      syn_valid_q  <= 1'b0;
      syn_src_q    <= '0;
      syn_dst_q    <= '0;
      syn_weight_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      cur_src      <= cur_src_n;
      dst_cnt      <= dst_n;
      syn_valid_q  <= syn_valid_n;
      syn_src_q    <= syn_src_n;
      syn_dst_q    <= syn_dst_n;
      syn_weight_q <= syn_weight_n;
      done_q       <= done_n;
      if (state == SCAN) begin
        wm_src_q <= cur_src;
        wm_dst_q <= dst_cnt;
      end
    end
  end

  // Next-state: pop in IDLE, probe one column per SCAN cycle, hold the event in EMIT.
  always_comb begin
    state_n      = state;
    cur_src_n    = cur_src;
    dst_n        = dst_cnt;
    syn_valid_n  = syn_valid_q;
    syn_src_n    = syn_src_q;
    syn_dst_n    = syn_dst_q;
    syn_weight_n = syn_weight_q;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          cur_src_n = fifo_mem[rd_ptr];
          dst_n     = '0;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (emittable) begin
          syn_valid_n  = 1'b1;
          syn_src_n    = cur_src;
          syn_dst_n    = dst_cnt;
          syn_weight_n = bus.wm_weight;
          state_n      = EMIT;
        end else if (dst_cnt == last_dst) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          dst_n = dst_cnt + 1'b1;
        end
      end
      EMIT: begin
        if (bus.syn_ready) begin
          syn_valid_n = 1'b0;
          if (dst_cnt == last_dst) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            dst_n   = dst_cnt + 1'b1;
            state_n = SCAN;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spike_fanout_dispatcher.sv
// Scoreboard bench for spike_fanout_dispatcher: a narrow instance (1-bit tags, 2 neurons)
// and a wide instance (2-bit tags, 3 neurons) share clock and reset.
// Expectations follow DISPATCH_SKIP_ZERO_EN as compiled.
module tb_spike_fanout_dispatcher;

  localparam int nw = 16;
`ifdef DISPATCH_SKIP_ZERO_EN
  localparam bit skip = 1'b1;
`else
  localparam bit skip = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  spike_fanout_dispatcher_if #(.numwidth(nw), .tagbits(1)) busa();
  spike_fanout_dispatcher_if #(.numwidth(nw), .tagbits(2)) busb();
  logic busy_a, done_a, busy_b, done_b;

  spike_fanout_dispatcher #(.numwidth(nw), .tagbits(1), .numneurons(2),
                            .fifodepth(4), .fifobits(2)) dut_a (
    .clk(clk), .rst(rst), .bus(busa), .busy(busy_a), .sweep_done(done_a));

  spike_fanout_dispatcher #(.numwidth(nw), .tagbits(2), .numneurons(3),
                            .fifodepth(4), .fifobits(2)) dut_b (
    .clk(clk), .rst(rst), .bus(busb), .busy(busy_b), .sweep_done(done_b));

  logic [nw:0] wa [2][2];
  logic [nw:0] wb [4][4];
  assign busa.wm_weight = wa[busa.wm_src_tag][busa.wm_dst_tag];
  assign busb.wm_weight = wb[busb.wm_src_tag][busb.wm_dst_tag];

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int ready_mode = 1;
  int exp_sweeps = 0;
  int got_sweeps = 0;
  int exp_sweeps_b = 0;
  int got_sweeps_b = 0;
  logic        mon_pv = 1'b0;
  logic        mon_pr = 1'b0;
  logic [63:0] mon_pd = '0;

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int src, input int dst, input logic [nw:0] w);
    return (64'(src) << 40) | (64'(dst) << 20) | 64'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready for the narrow instance: 0 = stall, 1 = always, 2 = random.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       busa.syn_ready = 1'b0;
      1:       busa.syn_ready = 1'b1;
      default: busa.syn_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Narrow-instance monitor: stall stability, scoreboard pop, sweep count.
  initial forever begin
    logic [63:0] cur;
    @(negedge clk);
    if (rst) begin
      mon_pv = 1'b0;
      continue;
    end
    cur = pack(busa.syn_src, busa.syn_dst, busa.syn_weight);
    if (mon_pv && !mon_pr) begin
      check_eq("stall_valid", 64'(busa.syn_valid), 64'd1);
      check_eq("stall_data", cur, mon_pd);
    end
    if (busa.syn_valid && busa.syn_ready) begin
      if (qa.size() == 0) check_eq("unexpected_event_a", cur, 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("event_a", cur, qa.pop_front());
    end
    if (done_a) got_sweeps++;
    mon_pv = busa.syn_valid;
    mon_pr = busa.syn_ready;
    mon_pd = cur;
  end

  // Wide-instance monitor: destination range and scoreboard pop.
  initial forever begin
    logic [63:0] cur;
    @(negedge clk);
    if (rst) continue;
    cur = pack(busb.syn_src, busb.syn_dst, busb.syn_weight);
    if (busb.syn_valid && busb.syn_ready) begin
      check_eq("dst_b_range", 64'(busb.syn_dst <= 2'd2), 64'd1);
      if (qb.size() == 0) check_eq("unexpected_event_b", cur, 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("event_b", cur, qb.pop_front());
    end
    if (done_b) got_sweeps_b++;
  end

  task automatic push_a(input int tag);
    int t = 0;
    busa.spike_valid = 1'b1;
    busa.spike_tag   = 1'(tag);
    while (!busa.spike_ready && t < 60) begin
      tick();
      t++;
    end
    if (!busa.spike_ready) begin
      check_eq("push_a_timeout", 64'(busa.spike_ready), 64'd1);
    end else begin
      for (int d = 0; d < 2; d++)
        if (!(skip && wa[tag][d][nw-1:0] == '0)) qa.push_back(pack(tag, d, wa[tag][d]));
      exp_sweeps++;
    end
    tick();
    busa.spike_valid = 1'b0;
  endtask

  task automatic push_b(input int tag);
    int t = 0;
    busb.spike_valid = 1'b1;
    busb.spike_tag   = 2'(tag);
    while (!busb.spike_ready && t < 60) begin
      tick();
      t++;
    end
    if (!busb.spike_ready) begin
      check_eq("push_b_timeout", 64'(busb.spike_ready), 64'd1);
    end else begin
      for (int d = 0; d < 3; d++)
        if (!(skip && wb[tag][d][nw-1:0] == '0)) qb.push_back(pack(tag, d, wb[tag][d]));
      exp_sweeps_b++;
    end
    tick();
    busb.spike_valid = 1'b0;
  endtask

  task automatic wait_valid_a();
    int t = 0;
    while (!busa.syn_valid && t < 20) begin
      tick();
      t++;
    end
    check_eq("wait_valid_a", 64'(busa.syn_valid), 64'd1);
  endtask

  task automatic drain_a();
    int t = 0;
    while ((qa.size() != 0 || busy_a) && t < 400) begin
      tick();
      t++;
    end
    repeat (2) tick();
    check_eq("drain_a_busy", 64'(busy_a), 64'd0);
    check_eq("drain_a_left", 64'(qa.size()), 64'd0);
    check_eq("sweeps_a", 64'(got_sweeps), 64'(exp_sweeps));
  endtask

  initial begin
    int c;
    busa.spike_valid = 1'b0;
    busa.spike_tag   = '0;
    busa.syn_ready   = 1'b1;
    busb.spike_valid = 1'b0;
    busb.spike_tag   = '0;
    busb.syn_ready   = 1'b1;
    wa[0][0] = 17'h1_0003;   // negative three
    wa[0][1] = 17'h1_0000;   // negative zero
    wa[1][0] = 17'h0_0005;
    wa[1][1] = 17'h0_0000;
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 4; d++)
        wb[s][d] = 17'(s * 4 + d + 1);
    wb[1][2] = 17'h1_0007;

    // Reset values held with no traffic
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      tick();
      check_eq("rst_spike_ready", 64'(busa.spike_ready), 64'd1);
      check_eq("rst_busy", 64'(busy_a), 64'd0);
      check_eq("rst_syn_valid", 64'(busa.syn_valid), 64'd0);
      check_eq("rst_sweep_done", 64'(done_a), 64'd0);
    end
    check_eq("rst_wm_tags", 64'({busa.wm_src_tag, busa.wm_dst_tag}), 64'd0);

    // Latency and sweep_done timing for row 1 = {5, 0}
    busa.spike_valid = 1'b1;
    busa.spike_tag   = 1'b1;
    qa.push_back(pack(1, 0, wa[1][0]));
    if (!skip) qa.push_back(pack(1, 1, wa[1][1]));
    exp_sweeps++;
    tick();
    busa.spike_valid = 1'b0;
    check_eq("lat_edge0_valid", 64'(busa.syn_valid), 64'd0);
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      c = i;
      if (i == 1) check_eq("lat_edge1_valid", 64'(busa.syn_valid), 64'd0);
      if (i == 2) begin
        check_eq("lat_edge2_valid", 64'(busa.syn_valid), 64'd1);
        check_eq("lat_edge2_dst", 64'(busa.syn_dst), 64'd0);
      end
      if (done_a) break;
    end
    check_eq("sweep_done_cycle", 64'(c), skip ? 64'd4 : 64'd5);
    tick();
    check_eq("sweep_done_width", 64'(done_a), 64'd0);
    drain_a();

    // Backpressure: stalled event stays put while the FIFO fills
    ready_mode = 0;
    push_a(0);
    wait_valid_a();
    push_a(1);
    push_a(0);
    push_a(1);
    push_a(0);
    check_eq("full_after_4", 64'(busa.spike_ready), 64'd0);
    repeat (3) begin
      tick();
      check_eq("full_hold", 64'(busa.spike_ready), 64'd0);
    end
    ready_mode = 1;
    push_a(1);
    drain_a();

    // Random downstream readiness
    ready_mode = 2;
    for (int i = 0; i < 10; i++) push_a(int'($urandom_range(0, 1)));
    ready_mode = 1;
    drain_a();

    // Wide instance: three destinations per row, counter stops at 2
    push_b(2);
    push_b(0);
    push_b(1);
    c = 0;
    while ((qb.size() != 0 || busy_b) && c < 200) begin
      tick();
      c++;
    end
    repeat (2) tick();
    check_eq("wide_busy", 64'(busy_b), 64'd0);
    check_eq("wide_left", 64'(qb.size()), 64'd0);
    check_eq("wide_last_dst", 64'(busb.wm_dst_tag), 64'd2);
    check_eq("wide_sweeps", 64'(got_sweeps_b), 64'(exp_sweeps_b));

    // Asynchronous reset mid-EMIT with spikes queued
    ready_mode = 0;
    push_a(0);
    wait_valid_a();
    push_a(1);
    push_a(0);
    push_a(1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_syn_valid", 64'(busa.syn_valid), 64'd0);
    check_eq("arst_busy", 64'(busy_a), 64'd0);
    check_eq("arst_spike_ready", 64'(busa.spike_ready), 64'd1);
    check_eq("arst_syn_fields", pack(busa.syn_src, busa.syn_dst, busa.syn_weight), 64'd0);
    qa.delete();
    exp_sweeps = 0;
    got_sweeps = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    ready_mode = 1;
    repeat (20) tick();
    check_eq("post_rst_busy", 64'(busy_a), 64'd0);
    check_eq("post_rst_valid", 64'(busa.syn_valid), 64'd0);
    check_eq("post_rst_sweeps", 64'(got_sweeps), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_fanout_dispatcher.md
# spike_fanout_dispatcher

Converts spike events from the neuron update stage into per-destination synaptic events by sweeping one row of the efferent weight matrix. Spike source tags are buffered in a small FIFO. For each buffered spike, the block walks the destination tags `0..numneurons-1`, reads each weight through the matrix's combinational read port, and emits weighted events over a valid/ready handshake to the synaptic current accumulator downstream.

## Interface
Parameters:
- `numwidth`, 16, magnitude width; weights are `numwidth+1` bits, with the sign in the MSB.
- `tagbits`, 1, neuron tag width.
- `numneurons`, 2, number of neurons; must be ≤ 2^tagbits.
- `fifodepth`, 4, spike FIFO entries; must be a power of two.
- `fifobits`, 2, log2(`fifodepth`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `spike_valid`  in  1  spike offered.
- `spike_tag`  in  tagbits  source neuron tag of the spike.
- `spike_ready`  out  1  equals `!fifo_full`; combinational from state.
- `wm_src_tag`  out  tagbits  row select to the weight matrix.
- `wm_dst_tag`  out  tagbits  column select to the weight matrix.
- `wm_weight`  in  numwidth+1  weight read combinationally from the matrix.
- `syn_valid`  out  1  synaptic event valid.
- `syn_ready`  in  1  downstream accepts.
- `syn_src`  out  tagbits  source tag of the event.
- `syn_dst`  out  tagbits  destination tag of the event.
- `syn_weight`  out  numwidth+1  signed weight of the event.
- `busy`  out  1  high when state ≠ IDLE or FIFO is non-empty.
- `sweep_done`  out  1  one-cycle pulse when a row sweep completes.

## Operation
- **FIFO push:**
  - A push occurs on `spike_valid && spike_ready`.
  - The FIFO pops only in IDLE.
  - When the FIFO is full, `spike_ready` is 0 even if a pop happens the same cycle; there is no pass-through.
  - Push and pop in the same cycle when not full are both performed.
  - Pointers wrap modulo `fifodepth`; a count register of `fifobits+1` bits distinguishes full from empty.
- **IDLE:**
  - If the FIFO is non-empty, pop the head into `cur_src`, clear `dst_cnt`, and go to SCAN.
- **SCAN:**
  - Drive `wm_src_tag=cur_src` and `wm_dst_tag=dst_cnt`, then sample `wm_weight` in the same cycle.
  - If the weight is emittable, register `syn_src`/`syn_dst`/`syn_weight`, set `syn_valid`, and go to EMIT.
  - Otherwise, if `dst_cnt==numneurons-1`, pulse `sweep_done` and go to IDLE.
  - Otherwise, increment `dst_cnt` and stay in SCAN.
- **EMIT:**
  - Hold all `syn_*` outputs stable while `syn_valid && !syn_ready`.
  - On `syn_ready`, clear `syn_valid`.
  - If this was the last destination, pulse `sweep_done` and go to IDLE; otherwise increment `dst_cnt` and go to SCAN.
- **Tag outputs outside SCAN:** `wm_src_tag`/`wm_dst_tag` hold their last values; they are 0 after reset.
- **Diagonal entry:** the destination equal to the source is handled like any other; self-connections are governed only by the weight value.
- **Weight format:** weights are passed through unmodified. There is no arithmetic; sign and magnitude are preserved bit-exact.

## Timing
- **Reset values:** all outputs are 0 except `spike_ready=1`. The FIFO is emptied, state is IDLE, and `dst_cnt=0`.
- **Reset mid-sweep:** reset asserted during a sweep aborts it immediately. `syn_valid` drops asynchronously, and queued spikes are discarded.
- **Latency:** a spike pushed at edge N into an empty FIFO while IDLE is popped at edge N+1 and SCANned during cycle N+1→N+2. Its first event has `syn_valid` high after edge N+2.
- **Throughput, all emittable and `syn_ready` held high:** one event every 2 cycles (SCAN, EMIT).
- **Throughput, skipped zero weights:** 1 cycle each.
- **Sweep boundary:** one IDLE cycle separates consecutive sweeps.
- **`sweep_done`:** asserted for exactly the one cycle after the edge that leaves the final SCAN/EMIT.

## Configuration
- `DISPATCH_SKIP_ZERO_EN` defined:
  - A weight is emittable only if it is ≠ 0.
  - Both all-zero and negative-zero (sign bit set, magnitude 0) are treated as no connection and skipped.
- `DISPATCH_SKIP_ZERO_EN` undefined:
  - Every destination is emittable, including zero weights.
  - Every sweep emits exactly `numneurons` events.

## Test plan
- **Reset values:** assert reset, release, hold `spike_valid=0` -> `spike_ready=1`, `busy=0`, `syn_valid=0`, `sweep_done=0` indefinitely.
- **Skip enabled:** with skip enabled, row 1 = {dst0: 0x00005, dst1: 0}, push tag 1, `syn_ready=1` -> exactly one event (src 1, dst 0, weight 0x00005) two cycles after push. `sweep_done` pulses one cycle after acceptance.
- **Skip disabled:** same matrix with skip disabled -> two events, dst 0 then dst 1, with weights 0x00005 then 0x00000.
- **Backpressure:** hold `syn_ready=0` for 5 cycles during EMIT -> `syn_valid`/`syn_dst`/`syn_weight` stable for all 5. Push 5 spikes meanwhile -> `spike_ready` goes 0 after the 4th push; the 5th is not accepted until a pop.
- **Asynchronous reset mid-sweep:** assert `rst` asynchronously mid-EMIT with 3 spikes queued -> `syn_valid` drops before the next edge. After release, no events are emitted and `busy=0`.
- **Wide configuration:** `tagbits=2`, `numneurons=3`, all weights nonzero -> `dst_cnt` stops at 2 and `syn_dst` never equals 3.
